// File: rtl/credit_pkg.sv
// Shared types and defaults for the credit drain block.
package credit_pkg;

    localparam int MAX_CREDITS_DEF = 3;
    localparam int CW_DEF          = 3;

    // FULL: count at ceiling, PART: in between, EMPTY: count at zero
    typedef enum logic [1:0] {
        FULL  = 2'd0,
        PART  = 2'd1,
        EMPTY = 2'd2
    } credit_state_t;

endpackage

// File: rtl/credit_sat_counter.sv
// Saturating up/down counter: resets to CEIL, never leaves 0..CEIL.
// Simultaneous inc and dec cancel.
module credit_sat_counter #(
    parameter int CEIL = 3,
    parameter int CW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] CEIL_C = CW'(CEIL);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    // Count update; ceiling and floor hold instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CEIL_C;
        end else if (inc && !dec && count != CEIL_C) begin
            count <= count + ONE_C;
        end else if (dec && !inc && count != '0) begin
            count <= count - ONE_C;
        end
    end

endmodule

// File: rtl/credit_drain_from_three.sv
// Credit pool with a FULL/PART/EMPTY FSM. Outputs come straight from
// registers, so nothing here is combinational from an input.
// Optional sticky overflow flag `err` is built when CREDIT_ERR_EN is defined.
module credit_drain_from_three
    import credit_pkg::*;
#(
    parameter int MAX_CREDITS = MAX_CREDITS_DEF,
    parameter int CW          = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic          ret_valid,
    output logic [CW-1:0] credits,
`ifdef CREDIT_ERR_EN
    output logic          err,
`endif
    output logic          empty,
    output logic          full
);

    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] TOP_M1_C = CW'(MAX_CREDITS - 1);

    credit_state_t state, state_nxt;
    logic fire;

    // issue_ready is a register, so the handshake never depends on itself
    assign fire = issue_valid && issue_ready;

    credit_sat_counter #(
        .CEIL (MAX_CREDITS),
        .CW   (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ret_valid),
        .dec   (fire),
        .count (credits)
    );

    // Next state from current state, current count and the handshake
    always_comb begin
        state_nxt = state;
        case (state)
            FULL: begin
                if (fire && !ret_valid)
                    state_nxt = (MAX_CREDITS == 1) ? EMPTY : PART;
            end
            PART: begin
                if (fire && !ret_valid && credits == ONE_C)
                    state_nxt = EMPTY;
                else if (ret_valid && !fire && credits == TOP_M1_C)
                    state_nxt = FULL;
            end
            EMPTY: begin
                if (ret_valid)
                    state_nxt = (MAX_CREDITS == 1) ? FULL : PART;
            end
            default: state_nxt = FULL;
        endcase
    end

    // State and decoded outputs registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FULL;
            issue_ready <= 1'b1;
            empty       <= 1'b0;
            full        <= 1'b1;
        end else begin
            state       <= state_nxt;
            issue_ready <= (state_nxt != EMPTY);
            empty       <= (state_nxt == EMPTY);
            full        <= (state_nxt == FULL);
        end
    end

`ifdef CREDIT_ERR_EN
    // Sticky overflow: a return with no fire while already at the ceiling.
    // Issuing while empty is plain backpressure and is not flagged.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (ret_valid && !fire && state == FULL)
            err <= 1'b1;
    end
`endif

endmodule
